apb_to_ahb_bridge: RTL
======================

Name: apb_to_ahb_bridge
Overview: Same-clock APB3/APB4 completer to AHB-Lite manager bridge, the reverse direction of the AHB-to-APB bridges already in the common-cell set. Lets APB-side agents (debug/test APB, security APB masters) issue single transfers into an AHB fabric or SRAM controller. Each APB access becomes exactly one AHB NONSEQ SINGLE transfer. pready is held low until the AHB data phase completes.
Parameters:
AW, 32, address width of paddr/haddr
DW, 32, data width of pwdata/prdata/hwdata/hrdata (32 or 64)
HPROT_DEF, 4'b0011, default hprot; bits [3:2] are used verbatim
Ports:
hclk  in  1  single clock for both APB and AHB sides
hreset  in  1  synchronous, active-high reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB write
paddr  in  AW  APB address
pwdata  in  DW  APB write data
pstrb  in  DW/8  APB4 write strobes (used only with the optional feature)
pprot  in  3  APB protection
prdata  out  DW  read data, registered
pready  out  1  transfer complete, registered
pslverr  out  1  error, valid with pready
haddr  out  AW  AHB address
htrans  out  2  IDLE(00)/NONSEQ(10) only
hwrite  out  1  AHB direction
hsize  out  3  AHB size
hprot  out  4  {HPROT_DEF[3:2], pprot[0], ~pprot[2]}
hwdata  out  DW  write data, driven in data phase
hrdata  in  DW  AHB read data
hready  in  1  AHB ready
hresp  in  1  0=OKAY, 1=ERROR
Behaviour:
- Reset state: prdata=0, pready=0, pslverr=0, haddr=0, htrans=IDLE, hwrite=0, hsize=0, hprot=0, hwdata=0, state=IDLE. No hburst or hmastlock ports: the integrator ties hburst=SINGLE and hmastlock=0.
- FSM IDLE: on psel&!penable (setup phase), capture paddr/pwrite/pwdata/pprot/size, go to ADDR. penable without a preceding setup is ignored.
- ADDR: htrans=NONSEQ, haddr = captured address with low log2(DW/8) bits zeroed (word size). hsize = log2(DW/8). Hold until hready=1, then go to DATA.
- DATA: htrans=IDLE, hwdata = captured data.
  - hready=1 & hresp=0: load prdata with hrdata (reads) or 0 (writes), go to RESP.
  - hresp=1 & hready=0: go to ERR.
- ERR: wait for hready=1, then go to RESP with pslverr=1.
- RESP: pready=1 for exactly one cycle with pslverr valid, then go to IDLE.
- Latency with zero AHB wait states: setup T0, ADDR T1, DATA T2, pready T3. Each AHB wait state adds one cycle. No back-to-back pipelining.
- psel deasserted mid-transfer (protocol violation): the AHB transfer completes, the result is discarded, pready is not asserted, and the FSM returns to IDLE.
- hreset mid-transfer: all outputs return to reset values on the next edge. The AHB slave shares the reset, so the abandoned data phase is legal.
Optional Feature:
APB_TO_AHB_PSTRB_EN: requires DW=32 (elaboration error otherwise). Write strobes are decoded as follows:
- 1111 → word. 0011/1100 → halfword, haddr[1]=strobe position. Single bit → byte, haddr[1:0]=bit index.
- 0000 → no AHB transfer; pready at T1 with pslverr=0.
- Any other pattern → no AHB transfer; pready at T1 with pslverr=1.
- Reads are always word.
Without the macro, pstrb is ignored and every transfer is word-sized.
Decomposition:
- Package apb_to_ahb_pkg: htrans/hsize/hresp localparams, state enum {IDLE,ADDR,DATA,ERR,RESP}, strobe-decode result struct {valid, err, size, lsb}.
- One combinational sub-module, apb_to_ahb_strb_dec (pstrb → size/lsb/valid), instantiated only under the macro.
Test Plan:
- Write 0x1000_0040 ← 0xDEAD_BEEF with zero waits → NONSEQ at T1, hwdata=0xDEADBEEF at T2, pready=1 and pslverr=0 at T3.
- Read 0x2000_0004 with 2 hready-low cycles, hrdata=0x1234_5678 → prdata=0x12345678, pready at T5.
- Read with two-cycle ERROR response → pslverr=1 with pready, prdata=0, FSM back in IDLE.
- paddr=0x0000_0003 with pprot=3'b001 → haddr=0x0000_0000, hsize=010, hprot=4'b0011.
- PSTRB_EN: pstrb=0100 → hsize=000, haddr[1:0]=10; pstrb=0101 → no NONSEQ, pslverr=1 at T1; pstrb=0000 → pready at T1, pslverr=0.
- hreset pulsed during DATA → next cycle htrans=IDLE, pready=0; the following write completes normally.

Source files
------------

// File: rtl/apb_to_ahb_pkg.sv
// Shared constants and types for the APB-completer to AHB-Lite-manager bridge.
// Covers AHB encodings, FSM states and the write-strobe decode result.
package apb_to_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // valid: issue an AHB transfer; err: reject without a transfer
    typedef struct packed {
        logic       valid;
        logic       err;
        logic [2:0] size;
        logic [1:0] lsb;
    } strb_dec_t;

endpackage

// File: rtl/apb_to_ahb_strb_dec.sv
// Decodes a 4-bit APB4 write strobe into an AHB transfer size and byte offset.
// Only contiguous, naturally aligned byte/halfword/word patterns are transferable.
module apb_to_ahb_strb_dec
    import apb_to_ahb_pkg::*;
(
    input  logic [3:0] pstrb,
    output strb_dec_t  dec
);

    always_comb begin
        dec = '{valid: 1'b0, err: 1'b1, size: HSIZE_WORD, lsb: 2'b00};
        case (pstrb)
            4'b1111: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_WORD, lsb: 2'b00};
            4'b0011: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_HALF, lsb: 2'b00};
            4'b1100: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_HALF, lsb: 2'b10};
            4'b0001: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_BYTE, lsb: 2'b00};
            4'b0010: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_BYTE, lsb: 2'b01};
            4'b0100: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_BYTE, lsb: 2'b10};
            4'b1000: dec = '{valid: 1'b1, err: 1'b0, size: HSIZE_BYTE, lsb: 2'b11};
            // An empty strobe is a legal no-op write, not an error.
            4'b0000: dec = '{valid: 1'b0, err: 1'b0, size: HSIZE_WORD, lsb: 2'b00};
            default: ;
        endcase
    end

endmodule

// File: rtl/apb_to_ahb_bridge.sv
// Same-clock APB3/APB4 completer that turns each APB access into one AHB-Lite NONSEQ SINGLE.
// Optional macro APB_TO_AHB_PSTRB_EN enables byte/halfword writes from pstrb (DW=32 only).
module apb_to_ahb_bridge
    import apb_to_ahb_pkg::*;
#(
    parameter int         AW        = 32,
    parameter int         DW        = 32,
    parameter logic [3:0] HPROT_DEF = 4'b0011
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [AW-1:0]   paddr,
    input  logic [DW-1:0]   pwdata,
    input  logic [DW/8-1:0] pstrb,
    input  logic [2:0]      pprot,
    output logic [DW-1:0]   prdata,
    output logic            pready,
    output logic            pslverr,
    output logic [AW-1:0]   haddr,
    output logic [1:0]      htrans,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [3:0]      hprot,
    output logic [DW-1:0]   hwdata,
    input  logic [DW-1:0]   hrdata,
    input  logic            hready,
    input  logic            hresp
);

    localparam int         BYTE_W   = $clog2(DW/8);
    localparam logic [2:0] HSIZE_BUS = 3'(BYTE_W);

    // Setup-phase decode: whether to issue an AHB transfer, and its shape.
    logic          setup_go;
    logic          setup_err;
    logic [2:0]    setup_size;
    logic [AW-1:0] setup_addr;
    logic          unused_bits;

`ifdef APB_TO_AHB_PSTRB_EN
    if (DW != 32) begin : g_dw_check
        $error("APB_TO_AHB_PSTRB_EN requires DW=32");
    end

    strb_dec_t dec;

    apb_to_ahb_strb_dec u_strb_dec (
        .pstrb (pstrb),
        .dec   (dec)
    );

    // Reads ignore the strobe and are always full word.
    assign setup_go    = !pwrite || dec.valid;
    assign setup_err   = pwrite && dec.err;
    assign setup_size  = pwrite ? dec.size : HSIZE_BUS;
    assign setup_addr  = {paddr[AW-1:BYTE_W], (pwrite ? dec.lsb : 2'b00)};
    assign unused_bits = ^{pprot[1], paddr[BYTE_W-1:0]};
`else
    assign setup_go    = 1'b1;
    assign setup_err   = 1'b0;
    assign setup_size  = HSIZE_BUS;
    assign setup_addr  = {paddr[AW-1:BYTE_W], {BYTE_W{1'b0}}};
    assign unused_bits = ^{pprot[1], paddr[BYTE_W-1:0], pstrb};
`endif

    state_e        state_reg,   state_next;
    logic          abort_reg,   abort_next;
    logic [DW-1:0] wdata_reg,   wdata_next;
    logic [AW-1:0] haddr_reg,   haddr_next;
    logic [1:0]    htrans_reg,  htrans_next;
    logic          hwrite_reg,  hwrite_next;
    logic [2:0]    hsize_reg,   hsize_next;
    logic [3:0]    hprot_reg,   hprot_next;
    logic [DW-1:0] hwdata_reg,  hwdata_next;
    logic [DW-1:0] prdata_reg,  prdata_next;
    logic          pready_reg,  pready_next;
    logic          pslverr_reg, pslverr_next;

    // The APB side is still waiting for this transfer only if psel never dropped.
    logic live;
    assign live = !abort_reg && psel;

    always_comb begin
        state_next   = state_reg;
        abort_next   = abort_reg;
        wdata_next   = wdata_reg;
        haddr_next   = haddr_reg;
        htrans_next  = htrans_reg;
        hwrite_next  = hwrite_reg;
        hsize_next   = hsize_reg;
        hprot_next   = hprot_reg;
        hwdata_next  = hwdata_reg;
        prdata_next  = prdata_reg;
        pready_next  = 1'b0;
        pslverr_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (psel && !penable) begin
                    abort_next = 1'b0;
                    wdata_next = pwdata;
                    if (setup_go) begin
                        state_next  = ST_ADDR;
                        htrans_next = HTRANS_NONSEQ;
                        haddr_next  = setup_addr;
                        hwrite_next = pwrite;
                        hsize_next  = setup_size;
                        hprot_next  = {HPROT_DEF[3:2], pprot[0], ~pprot[2]};
                    end else begin
                        state_next   = ST_RESP;
                        pready_next  = 1'b1;
                        pslverr_next = setup_err;
                        prdata_next  = '0;
                    end
                end
            end
            ST_ADDR: begin
                abort_next = abort_reg || !psel;
                if (hready) begin
                    state_next  = ST_DATA;
                    htrans_next = HTRANS_IDLE;
                    hwdata_next = wdata_reg;
                end
            end
            ST_DATA: begin
                abort_next = abort_reg || !psel;
                if (hready) begin
                    state_next = live ? ST_RESP : ST_IDLE;
                    if (live) begin
                        pready_next  = 1'b1;
                        pslverr_next = (hresp == HRESP_ERROR);
                        prdata_next  = (!hwrite_reg && hresp == HRESP_OKAY) ? hrdata : '0;
                    end
                end else if (hresp == HRESP_ERROR) begin
                    state_next = ST_ERR;
                end
            end
            ST_ERR: begin
                abort_next = abort_reg || !psel;
                if (hready) begin
                    state_next = live ? ST_RESP : ST_IDLE;
                    if (live) begin
                        pready_next  = 1'b1;
                        pslverr_next = 1'b1;
                        prdata_next  = '0;
                    end
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next  = ST_IDLE;
                htrans_next = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg   <= ST_IDLE;
            abort_reg   <= 1'b0;
            wdata_reg   <= '0;
            haddr_reg   <= '0;
            htrans_reg  <= HTRANS_IDLE;
            hwrite_reg  <= 1'b0;
            hsize_reg   <= 3'b000;
            hprot_reg   <= 4'b0000;
            hwdata_reg  <= '0;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            abort_reg   <= abort_next;
            wdata_reg   <= wdata_next;
            haddr_reg   <= haddr_next;
            htrans_reg  <= htrans_next;
            hwrite_reg  <= hwrite_next;
            hsize_reg   <= hsize_next;
            hprot_reg   <= hprot_next;
            hwdata_reg  <= hwdata_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
        end
    end

    assign haddr   = haddr_reg;
    assign htrans  = htrans_reg;
    assign hwrite  = hwrite_reg;
    assign hsize   = hsize_reg;
    assign hprot   = hprot_reg;
    assign hwdata  = hwdata_reg;
    assign prdata  = prdata_reg;
    assign pready  = pready_reg;
    assign pslverr = pslverr_reg;

endmodule
